// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: default widths, reset PC,
// state encodings and the timeout counter width helper.
package program_sequencer_pkg;

   localparam int          ADDR_W_DEF   = 16;
   localparam int          INS_W_DEF    = 21;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_FETCH = 2'b01;
   localparam logic [1:0] ST_EXEC  = 2'b10;
   localparam logic [1:0] ST_HALT  = 2'b11;

   // Bits needed to hold values 0..limit (at least one bit).
   function automatic int cntWidth(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/program_sequencer_fetch_timeout_counter.sv
// Counts consecutive un-acknowledged fetch cycles and flags the cycle in
// which the count would reach LIMIT. LIMIT = 0 disables expiry.
module program_sequencer_fetch_timeout_counter
   import program_sequencer_pkg::*;
#(
   parameter int LIMIT = 255
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expired
);

   localparam int               CNT_W = cntWidth(LIMIT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);

   logic [CNT_W-1:0] r_count;

   // Wait-cycle counter: cleared outside FETCH or on ack, saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   // Expiry fires on the wait cycle that brings the count up to LIMIT.
   assign o_expired = (LIMIT != 0) && i_count && (r_count == LAST);

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: owns PC and LR, fetches each instruction over a
// req/ack handshake, then spends one EXEC cycle applying decoder results.
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int                ADDR_W        = ADDR_W_DEF,
   parameter int                INS_W         = INS_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC      = ADDR_W'(RESET_PC_DEF),
   parameter int                FETCH_TIMEOUT = 255
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              step,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INS_W-1:0]  imem_data,
   output logic [INS_W-1:0]  INS,
   output logic [ADDR_W-1:0] INS_addr,
   input  logic              load_pc,
   input  logic              load_linkreg,
   input  logic              PC_source,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic [ADDR_W-1:0] new_linkreg,
   output logic              exec_en,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] linkreg,
   output logic [1:0]        state,
   output logic              bus_error
);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_lr;
   logic [INS_W-1:0]  r_ins;
   logic [ADDR_W-1:0] r_insAddr;
   logic              r_busError;
   logic              r_stepPend;

   logic [1:0] w_nextState;
   logic       w_inFetch;
   logic       w_inExec;
   logic       w_expired;

   assign w_inFetch = (r_state == ST_FETCH);
   assign w_inExec  = (r_state == ST_EXEC);

   program_sequencer_fetch_timeout_counter #(
      .LIMIT (FETCH_TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (!w_inFetch || imem_ack),
      .i_count   (w_inFetch && !imem_ack),
      .o_expired (w_expired)
   );

   // Next-state selection; HALT is absorbing and only reset leaves it.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:  if (run || step) w_nextState = ST_FETCH;
         ST_FETCH: begin
            if (imem_ack)       w_nextState = ST_EXEC;
            else if (w_expired) w_nextState = ST_HALT;
         end
         ST_EXEC:  w_nextState = (run && !r_stepPend) ? ST_FETCH : ST_IDLE;
         default:  w_nextState = ST_HALT;
      endcase
   end

   // State register; reset abandons any outstanding fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nextState;
   end

   // One-shot single-step flag: armed by a step in IDLE while stopped, spent in EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    r_stepPend <= 1'b0;
      else if ((r_state == ST_IDLE) && step && !run) r_stepPend <= 1'b1;
      else if (w_inExec)                             r_stepPend <= 1'b0;
   end

   // Capture the fetched word and its address so the decoder sees them stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ins     <= '0;
         r_insAddr <= '0;
      end else if (w_inFetch && imem_ack) begin
         r_ins     <= imem_data;
         r_insAddr <= r_pc;
      end
   end

   // PC and LR update at the end of EXEC; a return uses the LR value from before this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
         r_lr <= '0;
      end else if (w_inExec) begin
         if (load_pc) r_pc <= PC_source ? r_lr : new_pc;
         else         r_pc <= r_pc + ADDR_W'(1);
         if (load_linkreg) r_lr <= new_linkreg;
      end
   end

   // Sticky bus error raised when a fetch waits too long for its ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_busError <= 1'b0;
      else if (w_inFetch && w_expired) r_busError <= 1'b1;
   end

   assign imem_req  = w_inFetch;
   assign imem_addr = r_pc;
   assign exec_en   = w_inExec;
   assign INS       = r_ins;
   assign INS_addr  = r_insAddr;
   assign pc        = r_pc;
   assign linkreg   = r_lr;
   assign state     = r_state;
   assign bus_error = r_busError;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a memory responder with programmable ack
// latency, a small instruction decoder, and an instruction-level model of
// PC/LR behaviour checked after every executed instruction.
module tb_program_sequencer;
   import program_sequencer_pkg::*;

   localparam int TIMEOUT = 4;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_SETLR = 5'b00001;
   localparam logic [4:0] OP_JMP   = 5'b01100;
   localparam logic [4:0] OP_CALL  = 5'b01101;
   localparam logic [4:0] OP_RET   = 5'b01110;
   localparam logic [4:0] OP_RETLR = 5'b01111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        step;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [20:0] imem_data;
   logic [20:0] INS;
   logic [15:0] INS_addr;
   logic        load_pc;
   logic        load_linkreg;
   logic        PC_source;
   logic [15:0] new_pc;
   logic [15:0] new_linkreg;
   logic        exec_en;
   logic [15:0] pc;
   logic [15:0] linkreg;
   logic [1:0]  state;
   logic        bus_error;

   int checks   = 0;
   int failures = 0;

   logic [20:0] progMem [logic [15:0]];
   int          ackLatency = 1;
   bit          ackNever   = 1'b0;
   int          fetchCyc   = 0;
   bit          stepNoise  = 1'b0;
   logic [63:0] junk       = '0;
   logic [15:0] expPc;
   logic [15:0] expLr;

   program_sequencer #(
      .FETCH_TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .step         (step),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_data    (imem_data),
      .INS          (INS),
      .INS_addr     (INS_addr),
      .load_pc      (load_pc),
      .load_linkreg (load_linkreg),
      .PC_source    (PC_source),
      .new_pc       (new_pc),
      .new_linkreg  (new_linkreg),
      .exec_en      (exec_en),
      .pc           (pc),
      .linkreg      (linkreg),
      .state        (state),
      .bus_error    (bus_error)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Unwritten program locations read as NOP
   function automatic logic [20:0] memWord(input logic [15:0] a);
      if (progMem.exists(a)) return progMem[a];
      return {OP_NOP, 16'h0000};
   endfunction

   // Memory responder: acks on the ackLatency-th cycle of each request, refreshes decoder junk
   always @(negedge clk) begin
      junk = {$urandom, $urandom};
      if (imem_req) begin
         fetchCyc++;
         if (!ackNever && (fetchCyc >= ackLatency)) begin
            imem_ack  = 1'b1;
            imem_data = memWord(imem_addr);
         end else begin
            imem_ack  = 1'b0;
            imem_data = 21'($urandom);
         end
      end else begin
         fetchCyc = 0;
         imem_ack = 1'b0;
      end
   end

   // Decoder stand-in: real decode during EXEC, random garbage otherwise
   always_comb begin
      load_pc      = junk[0];
      load_linkreg = junk[1];
      PC_source    = junk[2];
      new_pc       = junk[18:3];
      new_linkreg  = junk[34:19];
      if (exec_en) begin
         load_pc      = 1'b0;
         load_linkreg = 1'b0;
         PC_source    = 1'b0;
         new_pc       = 16'h0000;
         new_linkreg  = 16'h0000;
         case (INS[20:16])
            OP_JMP: begin
               load_pc = 1'b1;
               new_pc  = INS[15:0];
            end
            OP_CALL: begin
               load_pc      = 1'b1;
               new_pc       = INS[15:0];
               load_linkreg = 1'b1;
               new_linkreg  = INS_addr + 16'd1;
            end
            OP_RET: begin
               load_pc   = 1'b1;
               PC_source = 1'b1;
            end
            OP_RETLR: begin
               load_pc      = 1'b1;
               PC_source    = 1'b1;
               load_linkreg = 1'b1;
               new_linkreg  = INS[15:0];
            end
            OP_SETLR: begin
               load_linkreg = 1'b1;
               new_linkreg  = INS[15:0];
            end
            default: ;
         endcase
      end
   end

   // Global time limit so the run can never hang
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one instruction through fetch and exec, then compare PC/LR with the model
   task automatic applyStimulus(input int latency, input bit expectIdle);
      int          reqCycles;
      bit          seenExec;
      logic [20:0] w;
      logic [15:0] nPc;
      logic [15:0] nLr;
      reqCycles  = 0;
      seenExec   = 1'b0;
      ackLatency = latency;
      for (int cyc = 0; (cyc < 20) && !seenExec; cyc++) begin
         if (exec_en) begin
            seenExec = 1'b1;
         end else begin
            if (imem_req) begin
               reqCycles++;
               checkOutput("fetchAddr", 32'(imem_addr), 32'(expPc));
            end
            if (stepNoise) step = ($urandom_range(0, 3) == 0);
            tick();
         end
      end
      if (!seenExec) begin
         checkOutput("execTimeout", 32'd0, 32'd1);
         return;
      end
      checkOutput("reqCycles", reqCycles, latency);
      checkOutput("execState", 32'(state), 32'(ST_EXEC));
      w = memWord(expPc);
      checkOutput("INS", 32'(INS), 32'(w));
      checkOutput("INS_addr", 32'(INS_addr), 32'(expPc));
      nPc = expPc + 16'd1;
      nLr = expLr;
      case (w[20:16])
         OP_JMP:   nPc = w[15:0];
         OP_CALL:  begin nPc = w[15:0]; nLr = expPc + 16'd1; end
         OP_RET:   nPc = expLr;
         OP_RETLR: begin nPc = expLr; nLr = w[15:0]; end
         OP_SETLR: nLr = w[15:0];
         default:  ;
      endcase
      tick();
      checkOutput("pcAfter", 32'(pc), 32'(nPc));
      checkOutput("lrAfter", 32'(linkreg), 32'(nLr));
      checkOutput("postExecState", 32'(state), expectIdle ? 32'(ST_IDLE) : 32'(ST_FETCH));
      expPc = nPc;
      expLr = nLr;
   endtask

   initial begin
      logic [15:0] imm;
      int          reqCount;
      bit          sawExec;

      rst_n     = 1'b0;
      run       = 1'b0;
      step      = 1'b0;
      imem_ack  = 1'b0;
      imem_data = '0;
      expPc     = 16'h0000;
      expLr     = 16'h0000;
      progMem[16'h0005] = {OP_CALL,  16'h0040};
      progMem[16'h0040] = {OP_RETLR, 16'h0099};
      progMem[16'h0006] = {OP_JMP,   16'hFFFF};

      #1;
      checkOutput("rstState", 32'(state), 32'(ST_IDLE));
      checkOutput("rstPc", 32'(pc), 32'h0000);
      checkOutput("rstLr", 32'(linkreg), 32'h0000);
      checkOutput("rstIns", 32'(INS), 32'h0);
      checkOutput("rstInsAddr", 32'(INS_addr), 32'h0);
      checkOutput("rstReq", 32'(imem_req), 32'd0);
      checkOutput("rstExecEn", 32'(exec_en), 32'd0);
      checkOutput("rstBusError", 32'(bus_error), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      run   = 1'b1;

      // Zero-wait free run over NOPs at 0..3
      for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0);
      checkOutput("pcAfter4", 32'(pc), 32'h0004);
      progMem[16'h0000] = {OP_JMP, 16'h0100};

      // Call from 0x0005 to 0x0040
      applyStimulus(1, 1'b0);
      applyStimulus(int'($urandom_range(1, 4)), 1'b0);
      checkOutput("callPc", 32'(pc), 32'h0040);
      checkOutput("callLr", 32'(linkreg), 32'h0006);

      // Return using old LR while LR is rewritten
      applyStimulus(2, 1'b0);
      checkOutput("retPc", 32'(pc), 32'h0006);
      checkOutput("retLr", 32'(linkreg), 32'h0099);

      // Jump to 0xFFFF, then sequential wrap to 0
      applyStimulus(1, 1'b0);
      checkOutput("jmpTopPc", 32'(pc), 32'hFFFF);
      applyStimulus(1, 1'b0);
      checkOutput("wrapPc", 32'(pc), 32'h0000);
      applyStimulus(1, 1'b0);

      // Random program in 0x0100..0x013F with random ack latency and step noise
      progMem[16'h0100] = {OP_SETLR, 16'h0110};
      for (int a = 16'h0101; a < 16'h0140; a++) begin
         imm = 16'h0100 + 16'($urandom_range(0, 63));
         case ($urandom_range(0, 5))
            0:       progMem[16'(a)] = {OP_NOP,   imm};
            1:       progMem[16'(a)] = {OP_JMP,   imm};
            2:       progMem[16'(a)] = {OP_CALL,  imm};
            3:       progMem[16'(a)] = {OP_RET,   imm};
            4:       progMem[16'(a)] = {OP_RETLR, imm};
            default: progMem[16'(a)] = {OP_SETLR, imm};
         endcase
      end
      stepNoise = 1'b1;
      for (int i = 0; i < 60; i++) applyStimulus(int'($urandom_range(1, 4)), 1'b0);
      stepNoise = 1'b0;
      step      = 1'b0;

      // Dropping run mid-fetch lets the instruction finish, then stops
      run = 1'b0;
      applyStimulus(int'($urandom_range(1, 4)), 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("idleReq", 32'(imem_req), 32'd0);
         checkOutput("idleState", 32'(state), 32'(ST_IDLE));
         checkOutput("idlePc", 32'(pc), 32'(expPc));
      end

      // Single step with 3-cycle ack, then a second step
      step = 1'b1;
      tick();
      step = 1'b0;
      applyStimulus(3, 1'b1);
      tick();
      tick();
      checkOutput("stepIdleReq", 32'(imem_req), 32'd0);
      checkOutput("stepIdleState", 32'(state), 32'(ST_IDLE));
      step = 1'b1;
      tick();
      step = 1'b0;
      applyStimulus(2, 1'b1);

      // Reset asserted in the middle of a fetch
      run      = 1'b1;
      ackNever = 1'b1;
      tick();
      checkOutput("midFetchReq", 32'(imem_req), 32'd1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRstReq", 32'(imem_req), 32'd0);
      checkOutput("asyncRstPc", 32'(pc), 32'h0000);
      checkOutput("asyncRstState", 32'(state), 32'(ST_IDLE));
      checkOutput("asyncRstLr", 32'(linkreg), 32'h0000);
      checkOutput("asyncRstExecEn", 32'(exec_en), 32'd0);
      run = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      checkOutput("postRstIdle", 32'(state), 32'(ST_IDLE));

      // Fetch that is never acknowledged times out into HALT
      run      = 1'b1;
      reqCount = 0;
      sawExec  = 1'b0;
      for (int cyc = 0; (cyc < 20) && (state != ST_HALT); cyc++) begin
         tick();
         if (imem_req) reqCount++;
         if (exec_en) sawExec = 1'b1;
      end
      checkOutput("toState", 32'(state), 32'(ST_HALT));
      checkOutput("toReqCycles", reqCount, TIMEOUT);
      checkOutput("toBusError", 32'(bus_error), 32'd1);
      checkOutput("toNoExec", 32'(sawExec), 32'd0);
      ackNever = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step = ~step;
         run  = (i != 1);
         tick();
         checkOutput("haltState", 32'(state), 32'(ST_HALT));
         checkOutput("haltReq", 32'(imem_req), 32'd0);
         checkOutput("haltExecEn", 32'(exec_en), 32'd0);
         checkOutput("haltBusError", 32'(bus_error), 32'd1);
      end
      step = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Owns the program counter (PC) and link register (LR) and sequences each instruction through FETCH -> EXEC.
- Fetches 21-bit instruction words from instruction memory over a req/ack handshake and holds the word stable for the combinational instruction decoder.
- Applies the decoder's load_pc / load_linkreg / PC_source results at the end of EXEC.
- Gates the decoder's datapath enables (A_ce, REGS_ce, flags_ce) so they take effect only during EXEC.
- Provides run/halt, single-step and a fetch timeout.

Parameters:
ADDR_W, 16, PC / LR / memory address width
INS_W, 21, instruction word width
RESET_PC, 16'h0000, PC value after reset
FETCH_TIMEOUT, 255, max cycles waiting for imem_ack; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = free-run; 0 = stop at next instruction boundary
step  in  1  single-cycle pulse; executes exactly one instruction while in IDLE
imem_req  out  1  fetch request, held until ack
imem_addr  out  ADDR_W  fetch address (= pc while imem_req=1)
imem_ack  in  1  data valid this cycle
imem_data  in  INS_W  instruction word
INS  out  INS_W  latched instruction, to decoder
INS_addr  out  ADDR_W  address of INS, to decoder
load_pc  in  1  from decoder
load_linkreg  in  1  from decoder
PC_source  in  1  from decoder: 0 = new_pc, 1 = LR (return)
new_pc  in  ADDR_W  from decoder
new_linkreg  in  ADDR_W  from decoder
exec_en  out  1  1 only in EXEC; ANDed with A_ce/REGS_ce/flags_ce at top level
pc  out  ADDR_W  current PC
linkreg  out  ADDR_W  current LR
state  out  2  encoded state, for debug
bus_error  out  1  sticky fetch timeout flag

Behaviour:
- Reset values (asynchronous, effective immediately on rst_n=0):
  - state=IDLE, pc=RESET_PC, linkreg=0, INS=0, INS_addr=0.
  - imem_req=0, exec_en=0, bus_error=0, timeout counter=0.
- Each outstanding request is abandoned on reset; late acks after reset are ignored because the block is not in FETCH.
- State encoding: IDLE=2'b00, FETCH=2'b01, EXEC=2'b10, HALT=2'b11.
- IDLE:
  - imem_req=0.
  - run=1 or step=1 -> FETCH next cycle.
  - A step seen in IDLE sets a one-shot flag, step_pend.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On imem_ack=1: INS<=imem_data, INS_addr<=pc, counter cleared -> EXEC.
  - Zero-wait memory (ack in the first FETCH cycle) is legal, giving a minimum of 2 cycles per instruction.
  - Counter increments each non-ack cycle. When FETCH_TIMEOUT!=0 and counter reaches FETCH_TIMEOUT: bus_error<=1 -> HALT, with no EXEC.
  - run falling during FETCH does not abort the fetch; the instruction completes.
- EXEC (exactly 1 cycle):
  - exec_en=1.
  - Next-PC priority: load_pc=1 and PC_source=1 -> pc<=linkreg (the old value, even if LR is written in the same cycle); load_pc=1 and PC_source=0 -> pc<=new_pc; otherwise pc<=pc+1 modulo 2^ADDR_W (16'hFFFF wraps to 0).
  - load_linkreg=1 -> linkreg<=new_linkreg. This is independent of the PC update; simultaneous call and LR write are allowed.
  - Next state: run=1 and step_pend=0 -> FETCH; otherwise -> IDLE, clearing step_pend.
- HALT:
  - Absorbing state; imem_req=0, exec_en=0.
  - Left only by reset. bus_error remains 1.
- step while run=1 is ignored.
- step pulses arriving during FETCH/EXEC are ignored.
- Decoder outputs are sampled only in EXEC; their values in other states are don't-care.

Decomposition:
- Shared package: state encodings, ADDR_W/INS_W defaults, RESET_PC.
- Optional sub-module: fetch_timeout_counter (counter, clear, compare, expired output).
- Everything else stays in one module.

Test Plan:
1. Reset, run=1, memory acks every fetch with 0 wait, INS opcode 5'b00000 -> imem_addr sequence 0,1,2,3; exec_en pulses every 2nd cycle; pc=4 after 4 EXECs.
2. INS=5'b01101 (call) with new_pc=16'h0040, fetched at addr 16'h0005 -> pc=16'h0040, linkreg=16'h0006 after EXEC; next fetch addr 16'h0040.
3. Return: linkreg=16'h0006, INS with load_pc=1, PC_source=1, load_linkreg=1, new_linkreg=16'h0099 -> pc=16'h0006 (old LR), linkreg=16'h0099.
4. pc=16'hFFFF, non-jump instruction -> pc wraps to 16'h0000.
5. run=0, step pulse in IDLE, 3-cycle ack delay -> exactly one EXEC, imem_req high 3 cycles then returns to IDLE; a second step performs the next fetch.
6. FETCH_TIMEOUT=4, ack never asserted -> bus_error=1 and state=HALT after 4 wait cycles, no exec_en. Assert rst_n=0 mid-FETCH in a separate run -> imem_req drops in the same cycle, pc=RESET_PC.
